// File: rtl/spi_sfr_bridge_pkg.sv
// Shared SFR bus widths, command-byte layout and bridge FSM encoding.
package sfr_bus_pkg;
  localparam int SFR_AW = 6;
  localparam int SFR_DW = 8;
  localparam int CMD_RW = 7;
  localparam int CMD_AI = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WDATA,
    ST_WSTB,
    ST_RDATA
  } state_e;

  function automatic logic [SFR_AW-1:0] addr_inc(input logic [SFR_AW-1:0] a);
    return a + SFR_AW'(1);
  endfunction
endpackage

// File: rtl/spi_sfr_bridge_if.sv
// SPI pins plus SFR bus; the bridge sits on the slave side of both.
interface spi_sfr_bridge_if;
  import sfr_bus_pkg::*;

  logic              spi_csn;
  logic              spi_sck;
  logic              spi_mosi;
  logic              spi_miso;
  logic [SFR_AW-1:0] sfr_addrs;
  logic [SFR_DW-1:0] sfr_wdata;
  logic              sfr_wctrl;
  logic              sfr_rctrl;
  logic [SFR_DW-1:0] sfr_rdata;

  modport slave (
    input  spi_csn, spi_sck, spi_mosi, sfr_rdata,
    output spi_miso, sfr_addrs, sfr_wdata, sfr_wctrl, sfr_rctrl
  );

  modport master (
    output spi_csn, spi_sck, spi_mosi, sfr_rdata,
    input  spi_miso, sfr_addrs, sfr_wdata, sfr_wctrl, sfr_rctrl
  );
endinterface

// File: rtl/spi_sfr_bridge_sync.sv
// Two-flop synchroniser plus history flop, yielding level and edge strobes.
module spi_pin_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);
  logic [2:0] sr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sr_q <= '0;
    else      sr_q <= {sr_q[1:0], d_i};
  end

  assign q_o    = sr_q[1];
  assign rise_o = sr_q[1] & ~sr_q[2];
  assign fall_o = ~sr_q[1] & sr_q[2];
endmodule

// File: rtl/spi_sfr_bridge.sv
// SPI mode-0 slave that turns command/data frames into SFR bus reads and writes.
module spi_sfr_bridge
  import sfr_bus_pkg::*;
#(
  parameter int WPULSE = 4
) (
  input logic             clk,
  input logic             rst,
  spi_sfr_bridge_if.slave bus
);
  localparam int CW = $clog2(WPULSE + 1);

  logic [2:0] pin_s, pin_rise, pin_fall;

  // index 2: csn, 1: sck, 0: mosi
  spi_pin_sync u_sync [2:0] (
    .clk   (clk),
    .rst   (rst),
    .d_i   ({bus.spi_csn, bus.spi_sck, bus.spi_mosi}),
    .q_o   (pin_s),
    .rise_o(pin_rise),
    .fall_o(pin_fall)
  );

  logic csn_rise, csn_fall, sck_rise, sck_fall, mosi_s, sync_unused;
  assign csn_rise    = pin_rise[2];
  assign csn_fall    = pin_fall[2];
  assign sck_rise    = pin_rise[1];
  assign sck_fall    = pin_fall[1];
  assign mosi_s      = pin_s[0];
  assign sync_unused = ^{pin_s[2:1], pin_rise[0], pin_fall[0]};

  state_e            state_q, state_d;
  logic [2:0]        bit_q;
  logic [7:0]        rx_q, tx_q;
  logic [SFR_AW-1:0] addr_q;
  logic [SFR_DW-1:0] wdata_q;
  logic              ai_q, skip_q, stop_q, start_q;
  logic [1:0]        rd_pipe_q;
  logic [CW-1:0]     cnt_q;

  logic       active, byte_done, rd_start, wstb_done, enter_cmd;
  logic [7:0] rx_nxt;

  assign active    = state_q inside {ST_CMD, ST_WDATA, ST_RDATA};
  assign rx_nxt    = {rx_q[6:0], mosi_s};
  assign byte_done = sck_rise & active & ~csn_rise & (bit_q == 3'd7);
  assign rd_start  = byte_done & ((state_q == ST_CMD & rx_nxt[CMD_RW]) | (state_q == ST_RDATA));
  assign wstb_done = (state_q == ST_WSTB) & (cnt_q == CW'(WPULSE - 1));
  assign enter_cmd = (state_d == ST_CMD) & (state_q != ST_CMD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // A strobe in flight always runs to completion; csn edges seen meanwhile decide where it exits.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (csn_fall) state_d = ST_CMD;
      ST_CMD:   if (csn_rise) state_d = ST_IDLE;
                else if (byte_done) state_d = rx_nxt[CMD_RW] ? ST_RDATA : ST_WDATA;
      ST_WDATA: if (csn_rise) state_d = ST_IDLE;
                else if (byte_done) state_d = ST_WSTB;
      ST_RDATA: if (csn_rise) state_d = ST_IDLE;
      ST_WSTB:  if (wstb_done) begin
                  if (csn_rise)                 state_d = ST_IDLE;
                  else if (csn_fall || start_q) state_d = ST_CMD;
                  else if (stop_q)              state_d = ST_IDLE;
                  else                          state_d = ST_WDATA;
                end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.sfr_wctrl = (state_q == ST_WSTB);
    bus.sfr_rctrl = rd_pipe_q[1];
    bus.sfr_addrs = addr_q;
    bus.sfr_wdata = wdata_q;
    bus.spi_miso  = ~bus.spi_csn & tx_q[7];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_q     <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ai_q      <= 1'b0;
      skip_q    <= 1'b0;
      stop_q    <= 1'b0;
      start_q   <= 1'b0;
      rd_pipe_q <= '0;
      cnt_q     <= '0;
    end else begin
      rd_pipe_q <= {rd_pipe_q[0], rd_start};

      if (enter_cmd) begin
        bit_q <= '0;
        rx_q  <= '0;
      end else if (sck_rise && active) begin
        bit_q <= bit_q + 3'd1;
        rx_q  <= rx_nxt;
      end

      if (byte_done && state_q == ST_CMD) begin
        addr_q <= rx_nxt[SFR_AW-1:0];
        ai_q   <= rx_nxt[CMD_AI];
      end else if ((rd_pipe_q[1] || wstb_done) && ai_q) begin
        addr_q <= addr_inc(addr_q);
      end

      if (byte_done && state_q == ST_WDATA) wdata_q <= rx_nxt;

      // The fall right after a capture would shift the fresh MSB out before the host samples it.
      if (enter_cmd) begin
        tx_q   <= '0;
        skip_q <= 1'b0;
      end else if (rd_pipe_q[1]) begin
        tx_q   <= bus.sfr_rdata;
        skip_q <= 1'b1;
      end else if (sck_fall) begin
        if (skip_q) skip_q <= 1'b0;
        else        tx_q   <= {tx_q[6:0], 1'b0};
      end

      if (state_q != ST_WSTB)  cnt_q <= '0;
      else if (!wstb_done)     cnt_q <= cnt_q + CW'(1);

      if (state_q != ST_WSTB) begin
        stop_q  <= 1'b0;
        start_q <= 1'b0;
      end else if (csn_rise) begin
        stop_q  <= 1'b1;
        start_q <= 1'b0;
      end else if (csn_fall) begin
        stop_q  <= 1'b0;
        start_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_spi_sfr_bridge.sv
// Directed frames against spi_sfr_bridge with a small SFR read model and strobe monitor.
module tb_spi_sfr_bridge;
  localparam int HALF   = 8;
  localparam int WPULSE = 4;

  logic clk, rst;
  int   total = 0;
  int   bad   = 0;

  spi_sfr_bridge_if bus ();

  spi_sfr_bridge #(.WPULSE(WPULSE)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (bus.sfr_addrs)
      6'h00:   bus.sfr_rdata = 8'hd0;
      6'h01:   bus.sfr_rdata = 8'h52;
      default: bus.sfr_rdata = 8'h00;
    endcase
  end

  typedef struct {
    logic [5:0] a;
    logic [7:0] d;
    int         len;
    bit         stb;
  } wr_t;

  wr_t  wq[$];
  wr_t  cur;
  logic wc_prev = 1'b0;
  int   rc_cnt  = 0;

  always @(negedge clk) begin
    wc_prev <= bus.sfr_wctrl;
    if (bus.sfr_rctrl) rc_cnt <= rc_cnt + 1;
    if (bus.sfr_wctrl && !wc_prev) begin
      cur.a   <= bus.sfr_addrs;
      cur.d   <= bus.sfr_wdata;
      cur.len <= 1;
      cur.stb <= 1'b1;
    end else if (bus.sfr_wctrl) begin
      cur.len <= cur.len + 1;
      if (bus.sfr_addrs != cur.a || bus.sfr_wdata != cur.d) cur.stb <= 1'b0;
    end else if (wc_prev) begin
      wq.push_back(cur);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      bus.spi_mosi = tx[i];
      cyc(HALF);
      bus.spi_sck = 1'b1;
      rx[i] = bus.spi_miso;
      cyc(HALF);
      bus.spi_sck = 1'b0;
    end
  endtask

  task automatic cs_lo();
    bus.spi_csn = 1'b0;
    cyc(HALF);
  endtask

  task automatic cs_hi();
    cyc(HALF);
    bus.spi_csn = 1'b1;
    cyc(3 * HALF);
  endtask

  task automatic chk_wr(input string tag, input int idx, input logic [5:0] a, input logic [7:0] d);
    if (idx >= wq.size()) begin
      chk({tag, "_missing"}, 32'(wq.size()), 32'(idx + 1));
    end else begin
      chk({tag, "_addr"}, 32'(wq[idx].a), 32'(a));
      chk({tag, "_data"}, 32'(wq[idx].d), 32'(d));
      chk({tag, "_len"}, 32'(wq[idx].len), 32'(WPULSE));
      chk({tag, "_stable"}, 32'(wq[idx].stb), 32'd1);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_addrs"}, 32'(bus.sfr_addrs), 32'd0);
    chk({tag, "_wdata"}, 32'(bus.sfr_wdata), 32'd0);
    chk({tag, "_wctrl"}, 32'(bus.sfr_wctrl), 32'd0);
    chk({tag, "_rctrl"}, 32'(bus.sfr_rctrl), 32'd0);
    chk({tag, "_miso"}, 32'(bus.spi_miso), 32'd0);
  endtask

  initial begin
    logic [7:0] r;
    int n0, rc0;

    rst = 1'b0;
    bus.spi_csn  = 1'b1;
    bus.spi_sck  = 1'b0;
    bus.spi_mosi = 1'b0;
    cyc(3);
    chk_zero("rst");
    rst = 1'b1;
    cyc(4);

    // single write, no auto-increment
    n0 = wq.size();
    cs_lo();
    xfer(8'h06, 8, r);
    xfer(8'h5a, 8, r);
    cs_hi();
    chk("w1_count", 32'(wq.size() - n0), 32'd1);
    chk_wr("w1", n0, 6'h06, 8'h5a);
    chk("w1_addr_after", 32'(bus.sfr_addrs), 32'h06);

    // auto-increment burst wrapping past 3f
    n0 = wq.size();
    cs_lo();
    xfer(8'h7e, 8, r);
    xfer(8'h11, 8, r);
    xfer(8'h22, 8, r);
    xfer(8'h33, 8, r);
    cs_hi();
    chk("wb_count", 32'(wq.size() - n0), 32'd3);
    chk_wr("wb0", n0,     6'h3e, 8'h11);
    chk_wr("wb1", n0 + 1, 6'h3f, 8'h22);
    chk_wr("wb2", n0 + 2, 6'h00, 8'h33);
    chk("wb_addr_after", 32'(bus.sfr_addrs), 32'h01);

    // read, no auto-increment
    rc0 = rc_cnt;
    cs_lo();
    xfer(8'h80, 8, r);
    chk("r1_rctrl_cmd", 32'(rc_cnt - rc0), 32'd1);
    xfer(8'h00, 8, r);
    chk("r1_byte0", 32'(r), 32'hd0);
    xfer(8'h00, 8, r);
    chk("r1_byte1", 32'(r), 32'hd0);
    cs_hi();
    chk("r1_rctrl_total", 32'(rc_cnt - rc0), 32'd3);
    chk("r1_addr_after", 32'(bus.sfr_addrs), 32'h00);

    // read burst with auto-increment
    rc0 = rc_cnt;
    cs_lo();
    xfer(8'hc0, 8, r);
    xfer(8'h00, 8, r);
    chk("rb_byte0", 32'(r), 32'hd0);
    xfer(8'h00, 8, r);
    chk("rb_byte1", 32'(r), 32'h52);
    xfer(8'h00, 8, r);
    chk("rb_byte2", 32'(r), 32'h00);
    cs_hi();
    chk("rb_rctrl_total", 32'(rc_cnt - rc0), 32'd4);
    chk("rb_addr_after", 32'(bus.sfr_addrs), 32'h04);
    chk("idle_miso", 32'(bus.spi_miso), 32'd0);

    // csn raised after 5 bits of a data byte
    n0 = wq.size();
    cs_lo();
    xfer(8'h06, 8, r);
    xfer(8'hff, 5, r);
    cs_hi();
    chk("abort_no_wctrl", 32'(wq.size() - n0), 32'd0);

    // csn raised one cycle into the strobe
    n0 = wq.size();
    cs_lo();
    xfer(8'h08, 8, r);
    xfer(8'ha5, 7, r);
    bus.spi_mosi = 1'b1;
    cyc(HALF);
    bus.spi_sck = 1'b1;
    cyc(2);
    bus.spi_csn = 1'b1;
    cyc(HALF);
    bus.spi_sck = 1'b0;
    cyc(3 * HALF);
    chk("csw_count", 32'(wq.size() - n0), 32'd1);
    chk_wr("csw", n0, 6'h08, 8'ha5);
    chk("csw_addr_after", 32'(bus.sfr_addrs), 32'h08);

    // async reset in the middle of a strobe
    cs_lo();
    xfer(8'h0a, 8, r);
    xfer(8'hfe, 7, r);
    bus.spi_mosi = 1'b1;
    cyc(HALF);
    bus.spi_sck = 1'b1;
    cyc(4);
    chk("pre_rst_wctrl", 32'(bus.sfr_wctrl), 32'd1);
    rst = 1'b0;
    #1;
    chk_zero("mid_rst");
    cyc(1);
    rst = 1'b1;
    cyc(HALF);
    bus.spi_sck = 1'b0;
    cs_hi();

    n0 = wq.size();
    cs_lo();
    xfer(8'h04, 8, r);
    xfer(8'h01, 8, r);
    cs_hi();
    chk("post_rst_count", 32'(wq.size() - n0), 32'd1);
    chk_wr("post_rst", n0, 6'h04, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
